fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_WIDTH, default 16: program counter and branch target width.
REQ-002 Parameter INSTR_WIDTH, default 16: instruction word width.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter NOP_INSTR, default all-zero: bubble word inserted on flush.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall_ctrl  input  1  from hazard unit (driven on falling edge); hold PC and IF/ID.
REQ-008 flush_ctrl  input  1  from hazard unit; redirect PC and squash IF/ID.
REQ-009 branch_target  input  PC_WIDTH  redirect address, valid while flush_ctrl=1.
REQ-010 instr_in  input  INSTR_WIDTH  instruction memory read data for the current pc_out, combinational.
REQ-011 pc_out  output  PC_WIDTH  fetch address to instruction memory.
REQ-012 if_id_instr  output  INSTR_WIDTH  IF/ID register instruction.
REQ-013 if_id_pc  output  PC_WIDTH  IF/ID register PC of if_id_instr.
REQ-014 if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-015 fetch_state  output  2  current FSM state: 0 START, 1 RUN, 2 HOLD, 3 REDIRECT.

Function
REQ-016 The block SHALL sample stall_ctrl, flush_ctrl and branch_target on the rising edge of clock only.
REQ-017 The FSM SHALL implement states START, RUN, HOLD and REDIRECT.
- START: entered on reset. Lasts one cycle. Next state is RUN unless flush or stall applies.
REQ-018 Priority on every non-reset edge SHALL be reset > flush_ctrl > stall_ctrl > normal fetch.
REQ-019 Flush (flush_ctrl=1, any state):
- pc_out <= branch_target
- if_id_instr <= NOP_INSTR, if_id_pc <= 0, if_id_valid <= 0
- next state REDIRECT
- a simultaneous stall_ctrl is ignored
REQ-020 Stall (flush_ctrl=0, stall_ctrl=1):
- pc_out and all IF/ID outputs hold their values
- next state HOLD
- HOLD persists while stall_ctrl=1, for any number of cycles
REQ-021 Normal fetch (both controls 0):
- if_id_instr <= instr_in, if_id_pc <= pc_out, if_id_valid <= 1
- pc_out <= pc_out + 1
- next state RUN
REQ-022 REDIRECT SHALL last exactly one cycle when no control is asserted; its normal fetch captures the instruction at branch_target.
REQ-023 PC increment SHALL be modulo 2^PC_WIDTH: all-ones wraps to 0 with no flag.
REQ-024 Latency: an instruction presented on instr_in appears on if_id_instr one rising edge later, absent stall or flush.
REQ-025 A flush arriving in HOLD SHALL end the hold immediately; the held IF/ID contents are discarded.
REQ-026 A 2-cycle stall pulse (swap sequence) SHALL leave pc_out and IF/ID unchanged for exactly two edges.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL load:
- pc_out=RESET_PC
- if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0
- fetch_state=START
- any counters = 0
REQ-028 Reset SHALL override stall_ctrl and flush_ctrl, including mid-stall and mid-redirect.
REQ-029 On the first edge after reset deasserts, the block SHALL fetch from RESET_PC.

Configuration
REQ-030 With macro FETCH_PERF_COUNT_EN defined, the block SHALL add two outputs, both cleared by reset:
- stall_cycles (16 bits): counts edges taking the stall branch, saturating at 16'hFFFF.
- flush_count (16 bits): counts edges taking the flush branch, saturating at 16'hFFFF.
REQ-031 Without FETCH_PERF_COUNT_EN, these ports and their counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-032 Reset, then 4 idle cycles with instr_in=0x1000+pc -> if_id_pc = 0,1,2; if_id_instr = 0x1000,0x1001,0x1002; if_id_valid=1 from the second edge.
REQ-033 stall_ctrl high for 2 edges at pc_out=5 -> pc_out stays 5 and IF/ID holds pc 4; fetch resumes with pc 5 captured next; fetch_state HOLD then RUN.
REQ-034 flush_ctrl=1 with branch_target=0x0040 -> next edge: pc_out=0x0040, if_id_valid=0, if_id_instr=NOP_INSTR; following edge: if_id_pc=0x0040, valid=1.
REQ-035 flush_ctrl and stall_ctrl both high -> flush wins: pc_out=branch_target, state REDIRECT.
REQ-036 pc_out=0xFFFF, normal fetch -> pc_out=0x0000, if_id_pc=0xFFFF.
REQ-037 reset asserted during HOLD with FETCH_PERF_COUNT_EN defined -> pc_out=RESET_PC, state START, stall_cycles=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// control FSM. Optional perf counters are enabled with FETCH_PERF_COUNT_EN.
module fetch_stage #(
   parameter int                     PC_WIDTH    = 16,
   parameter int                     INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   stall_ctrl,
   input  logic                   flush_ctrl,
   input  logic [PC_WIDTH-1:0]    branch_target,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic [INSTR_WIDTH-1:0] if_id_instr,
   output logic [PC_WIDTH-1:0]    if_id_pc,
   output logic                   if_id_valid,
   output logic [1:0]             fetch_state
`ifdef FETCH_PERF_COUNT_EN
   ,
   output logic [15:0]            stall_cycles,
   output logic [15:0]            flush_count
`endif
);

   typedef enum logic [1:0] {
      ST_START    = 2'd0,
      ST_RUN      = 2'd1,
      ST_HOLD     = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [15:0]         CNT_MAX  = 16'hFFFF;
   localparam logic [15:0]         CNT_ONE  = 16'd1;

   state_t state;

   assign fetch_state = state;

   // Priority: reset > flush > stall > normal fetch. Stall holds every
   // register, so only the state changes in that branch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_START;
         pc_out      <= RESET_PC;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else if (flush_ctrl) begin
         state       <= ST_REDIRECT;
         pc_out      <= branch_target;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else if (stall_ctrl) begin
         state       <= ST_HOLD;
      end else begin
         state       <= ST_RUN;
         pc_out      <= pc_out + PC_ONE;
         if_id_instr <= instr_in;
         if_id_pc    <= pc_out;
         if_id_valid <= 1'b1;
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   // Both counters saturate rather than wrap so a long run never reads low.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else if (flush_ctrl) begin
         if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
      end else if (stall_ctrl) begin
         if (stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a reference model of
// the fetch rules; instruction memory returns 0x1000 + address.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall_ctrl = 1'b0;
   logic        flush_ctrl = 1'b0;
   logic [15:0] branch_target = '0;
   logic [15:0] instr_in;
   logic [15:0] pc_out;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc;
   logic        if_id_valid;
   logic [1:0]  fetch_state;
`ifdef FETCH_PERF_COUNT_EN
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model state (plain integers, spec encoding of states).
   int m_pc, m_instr, m_ipc, m_valid, m_state, m_stalls, m_flushes;

   always #5 clock = ~clock;

   assign instr_in = 16'h1000 + pc_out;

   fetch_stage dut (
      .clock         (clock),
      .reset         (reset),
      .stall_ctrl    (stall_ctrl),
      .flush_ctrl    (flush_ctrl),
      .branch_target (branch_target),
      .instr_in      (instr_in),
      .pc_out        (pc_out),
      .if_id_instr   (if_id_instr),
      .if_id_pc      (if_id_pc),
      .if_id_valid   (if_id_valid),
      .fetch_state   (fetch_state)
`ifdef FETCH_PERF_COUNT_EN
      ,
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: inputs driven on the falling edge, model advanced and all
   // outputs compared just after the rising edge.
   task automatic step(input bit r, input bit s, input bit f, input int bt);
      @(negedge clock);
      reset = r; stall_ctrl = s; flush_ctrl = f; branch_target = bt[15:0];
      @(posedge clock);
      #1;
      if (r) begin
         m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_state = 0;
         m_stalls = 0; m_flushes = 0;
      end else if (f) begin
         m_pc = bt % 65536; m_instr = 0; m_ipc = 0; m_valid = 0; m_state = 3;
         if (m_flushes < 65535) m_flushes++;
      end else if (s) begin
         m_state = 2;
         if (m_stalls < 65535) m_stalls++;
      end else begin
         m_ipc = m_pc; m_instr = (4096 + m_pc) % 65536; m_valid = 1;
         m_pc = (m_pc + 1) % 65536; m_state = 1;
      end
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("if_id_instr", 32'(if_id_instr), 32'(m_instr));
      check("if_id_pc", 32'(if_id_pc), 32'(m_ipc));
      check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check("fetch_state", 32'(fetch_state), 32'(m_state));
`ifdef FETCH_PERF_COUNT_EN
      check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      check("flush_count", 32'(flush_count), 32'(m_flushes));
`endif
   endtask

   initial begin
      // Reset, then idle fetch from address 0.
      step(1, 0, 0, 0);
      step(1, 1, 1, 16'h00AA);
      check("reset_pc", 32'(pc_out), 32'h0);
      check("reset_state", 32'(fetch_state), 32'd0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      check("run_pc5", 32'(pc_out), 32'd5);
      check("run_ipc4", 32'(if_id_pc), 32'd4);

      // Two-edge stall at pc 5, then resume.
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("hold_pc", 32'(pc_out), 32'd5);
      check("hold_ipc", 32'(if_id_pc), 32'd4);
      check("hold_state", 32'(fetch_state), 32'd2);
      step(0, 0, 0, 0);
      check("resume_ipc", 32'(if_id_pc), 32'd5);
      check("resume_state", 32'(fetch_state), 32'd1);

      // Flush to 0x40, then redirect fetch.
      step(0, 0, 1, 16'h0040);
      check("flush_pc", 32'(pc_out), 32'h40);
      check("flush_valid", 32'(if_id_valid), 32'd0);
      step(0, 0, 0, 0);
      check("redir_ipc", 32'(if_id_pc), 32'h40);
      check("redir_instr", 32'(if_id_instr), 32'h1040);

      // Flush beats stall; flush during hold.
      step(0, 1, 1, 16'h0123);
      check("flush_wins_state", 32'(fetch_state), 32'd3);
      step(0, 1, 0, 0);
      step(0, 1, 1, 16'h0200);
      step(0, 0, 0, 0);

      // PC wrap at all-ones.
      step(0, 0, 1, 16'hFFFF);
      step(0, 0, 0, 0);
      check("wrap_pc", 32'(pc_out), 32'h0);
      check("wrap_ipc", 32'(if_id_pc), 32'hFFFF);

      // Reset in the middle of a hold and of a redirect.
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      check("rst_hold_state", 32'(fetch_state), 32'd0);
      step(0, 0, 1, 16'h0777);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      check("post_rst_ipc", 32'(if_id_pc), 32'h0);

      // Randomized control traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), int'($urandom_range(0, 65535)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
